// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and helpers for the shift sequencer: FSM states, direction codes
// and the command-length clamp.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // A length of zero or anything wider than the register means "whole register".
  function automatic int clamp_len(input int len, input int n);
    return ((len == 0) || (len > n)) ? n : len;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/response bus between a requester (master) and the shift sequencer (slave).
interface shift_seq_ctrl_if #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [N-1:0]     cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic             busy;
  logic             done;
  logic [N-1:0]     rx_data;

  modport master (
    output cmd_valid, cmd_dir, cmd_data, cmd_len,
    input  cmd_ready, busy, done, rx_data
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_data, cmd_len,
    output cmd_ready, busy, done, rx_data
  );

endinterface

// File: rtl/shift_seq_ctrl_core.sv
// N-bit bidirectional shift register with parallel load; also exposes the
// value it would take on a shift so the controller can capture it on that edge.
module shift_seq_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [N-1:0] i_load_data,
  input  logic         i_shift,
  input  logic         i_dir,
  input  logic         i_serial_in,
  output logic [N-1:0] o_q,
  output logic [N-1:0] o_shifted
);

  logic [N-1:0] r_q;
  logic [N-1:0] w_shifted;

  assign w_shifted = i_dir ? {r_q[N-2:0], i_serial_in}
                           : {i_serial_in, r_q[N-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_q <= '0;
    else if (i_load)  r_q <= i_load_data;
    else if (i_shift) r_q <= w_shifted;
  end

  assign o_q       = r_q;
  assign o_shifted = w_shifted;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command-driven shift sequencer: loads a word, shifts L bits out while capturing
// serial_in, then pulses done with the residue. Optional prescaler: SHIFT_SEQ_DIV_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1),
  parameter int DIV   = 4
) (
  input  logic           clk,
  input  logic           reset,
  shift_seq_ctrl_if.slave bus,
  input  logic           i_serial_in,
  output logic           o_serial_out,
  output logic           o_shift_en
);

  if ((N < 2) || (DIV < 1)) begin : g_param_check
    $error("shift_seq_ctrl: N must be >= 2 and DIV >= 1");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [N-1:0]     r_rx;

  logic             w_accept;
  logic             w_tick;
  logic             w_shift;
  logic [CNT_W-1:0] w_len;
  logic [N-1:0]     w_q;
  logic [N-1:0]     w_shifted;

  assign w_accept = (r_state == IDLE) && bus.cmd_valid;
  assign w_len    = CNT_W'(clamp_len(int'(bus.cmd_len), N));
  assign w_shift  = (r_state == SHIFT) && w_tick;

`ifdef SHIFT_SEQ_DIV_EN
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] r_pre;

  // Prescaler restarts at every accept so the first shift lands DIV cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_pre <= '0;
    else if (w_accept)           r_pre <= '0;
    else if (r_state == SHIFT)   r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
  end

  assign w_tick = (r_pre == PRE_MAX);
`else
  assign w_tick = 1'b1;
`endif

  shift_seq_core #(.N(N)) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept),
    .i_load_data (bus.cmd_data),
    .i_shift     (w_shift),
    .i_dir       (r_dir),
    .i_serial_in (i_serial_in),
    .o_q         (w_q),
    .o_shifted   (w_shifted)
  );

  // rx_data takes the post-shift value on the final edge so it is valid alongside done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_RIGHT;
      r_rx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_state <= SHIFT;
            r_cnt   <= w_len;
            r_dir   <= bus.cmd_dir;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state <= DONE;
              r_rx    <= w_shifted;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.rx_data   = r_rx;
  assign o_shift_en    = w_shift;
  assign o_serial_out  = (r_state == SHIFT) ? ((r_dir == DIR_LEFT) ? w_q[N-1] : w_q[0]) : 1'b0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (N=8); cycle expectations scale
// with the prescaler ratio when SHIFT_SEQ_DIV_EN is defined.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_DIV_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic clk;
  logic reset;
  logic serialIn;
  logic serialOut;
  logic shiftEn;

  int testsRun;
  int testsFailed;

  shift_seq_ctrl_if #(.N(8), .CNT_W(4)) bus ();

  shift_seq_ctrl #(.N(8), .CNT_W(4), .DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .i_serial_in  (serialIn),
    .o_serial_out (serialOut),
    .o_shift_en   (shiftEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command, then check every cycle up to done and the return to idle.
  task automatic run_xfer(input string nm, input logic [7:0] data, input logic dir,
                          input logic [3:0] len, input logic sin, input int L,
                          input logic [7:0] expSeq, input logic [7:0] expRx);
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = data;
    bus.cmd_dir   = dir;
    bus.cmd_len   = len;
    serialIn      = sin;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = ~data;
    bus.cmd_dir   = ~dir;
    for (int c = 1; c <= D * L; c++) begin
      if (shiftEn === 1'b1) pulses++;
      testsRun++;
      if (shiftEn !== ((c % D) == 0)) begin
        testsFailed++;
        $display("[TB] FAIL %s shift_en cycle %0d got %b want %b", nm, c, shiftEn, ((c % D) == 0));
      end
      if ((c % D) == 0) begin
        testsRun++;
        if (serialOut !== expSeq[c / D - 1]) begin
          testsFailed++;
          $display("[TB] FAIL %s serial_out cycle %0d got %b want %b", nm, c, serialOut, expSeq[c / D - 1]);
        end
      end
      testsRun++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL %s early done/ready cycle %0d got %b/%b want 0/0", nm, c, bus.done, bus.cmd_ready);
      end
      @(posedge clk);
      #1;
    end
    testsRun++;
    if (bus.done !== 1'b1 || shiftEn !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s done cycle %0d got done=%b shift_en=%b want 1/0", nm, D * L + 1, bus.done, shiftEn);
    end
    testsRun++;
    if (bus.rx_data !== expRx) begin
      testsFailed++;
      $display("[TB] FAIL %s rx_data got %h want %h", nm, bus.rx_data, expRx);
    end
    testsRun++;
    if (pulses != L) begin
      testsFailed++;
      $display("[TB] FAIL %s shift_en pulse count got %0d want %0d", nm, pulses, L);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL %s idle ready/done/busy got %b/%b/%b want 1/0/0", nm, bus.cmd_ready, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    testsRun++;
    if ({bus.busy, bus.done, shiftEn, serialOut} !== 4'b0000 || bus.rx_data !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs got busy=%b done=%b en=%b so=%b rx=%h want all 0",
               bus.busy, bus.done, shiftEn, serialOut, bus.rx_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if (bus.cmd_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset cmd_ready got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_right_full();
    run_xfer("right_full", 8'hA5, 1'b0, 4'd0, 1'b1, 8, 8'hA5, 8'hFF);
  endtask

  task automatic test_left_partial();
    run_xfer("left_len4", 8'h3C, 1'b1, 4'd4, 1'b0, 4, 8'h0C, 8'hC0);
  endtask

  task automatic test_len_clamp();
    run_xfer("len_clamp", 8'h5A, 1'b0, 4'd12, 1'b0, 8, 8'h5A, 8'h00);
  endtask

  task automatic test_short();
    run_xfer("len2", 8'h96, 1'b0, 4'd2, 1'b1, 2, 8'h02, 8'hE5);
  endtask

  task automatic test_back_to_back();
    int waited;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'hF0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_len   = 4'd3;
    serialIn      = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_data  = 8'h0F;
    bus.cmd_dir   = 1'b1;
    bus.cmd_len   = 4'd2;
    for (int c = 1; c <= D * 3 + 1; c++) begin
      testsRun++;
      if (bus.cmd_ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL b2b ready cycle %0d got %b want 0", c, bus.cmd_ready);
      end
      if (c == D * 3 + 1) begin
        testsRun++;
        if (bus.done !== 1'b1 || bus.rx_data !== 8'h1E) begin
          testsFailed++;
          $display("[TB] FAIL b2b first done/rx got %b/%h want 1/1e", bus.done, bus.rx_data);
        end
      end
      @(posedge clk);
      #1;
    end
    testsRun++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b reopen ready/busy got %b/%b want 1/0", bus.cmd_ready, bus.busy);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    testsRun++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b second accept busy/ready got %b/%b want 1/0", bus.busy, bus.cmd_ready);
    end
    waited = 1;
    while (bus.done !== 1'b1 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    testsRun++;
    if (waited != D * 2 + 1 || bus.rx_data !== 8'h3C) begin
      testsFailed++;
      $display("[TB] FAIL b2b second done cycle/rx got %0d/%h want %0d/3c", waited, bus.rx_data, D * 2 + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'hA5;
    bus.cmd_dir   = 1'b0;
    bus.cmd_len   = 4'd0;
    serialIn      = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (D * 2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    testsRun++;
    if ({bus.busy, bus.done, shiftEn, serialOut} !== 4'b0000 || bus.rx_data !== 8'h00 || bus.cmd_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid outputs got busy=%b done=%b en=%b so=%b rx=%h rdy=%b want 0/0/0/0/00/1",
               bus.busy, bus.done, shiftEn, serialOut, bus.rx_data, bus.cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      testsRun++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid spurious done/busy got %b/%b want 0/0", bus.done, bus.busy);
      end
    end
    run_xfer("after_reset", 8'h81, 1'b1, 4'd0, 1'b0, 8, 8'h81, 8'h00);
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.cmd_dir   = 1'b0;
    bus.cmd_len   = 4'd0;
    serialIn      = 1'b0;
    test_reset();
    test_right_full();
    test_left_partial();
    test_len_clamp();
    test_short();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
